// File: rtl/avalon_slave_ram.sv
// Avalon-MM slave register-file RAM with programmable wait states and a fixed-latency read pipeline.
// Define AVALON_RAM_CLEAR_EN to zero the memory array on reset; otherwise contents survive reset.
module avalon_slave_ram #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 4,
    parameter int WAIT_CYCLES  = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic              waitrequest,
    output logic              readdatavalid,
    output logic [DATA_W-1:0] readdata
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

    logic              rw;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_W-1:0] dat_q [READ_LATENCY];
    logic [DATA_W-1:0] dat_d [READ_LATENCY];

    assign rw          = read | write;
    assign waitrequest = ~(rw & (wcnt_q == WAIT_C));
    // A request sitting on a reset edge must not be accepted.
    assign accept      = rw & ~waitrequest & ~reset;
    assign wr_acc      = accept & write;
    assign rd_acc      = accept & read & ~write;

    always_comb begin
        wcnt_d = wcnt_q;
        if (!rw || accept) begin
            wcnt_d = '0;
        end else if (wcnt_q < WAIT_C) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    // Data stages only load behind a valid bit, so the last stage holds the last delivered word.
    always_comb begin
        vld_d    = '0;
        dat_d    = dat_q;
        vld_d[0] = rd_acc;
        if (rd_acc) begin
            dat_d[0] = mem_q[address];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) begin
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wcnt_q <= '0;
            vld_q  <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            wcnt_q <= wcnt_d;
            vld_q  <= vld_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    always_ff @(posedge clock) begin
`ifdef AVALON_RAM_CLEAR_EN
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_acc) begin
            mem_q[address] <= writedata;
        end
`else
        if (wr_acc) begin
            mem_q[address] <= writedata;
        end
`endif
    end

    assign readdatavalid = vld_q[READ_LATENCY-1];
    assign readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_avalon_slave_ram.sv
// Scoreboard bench for avalon_slave_ram: three instances (WAIT/LAT = 3/1, 0/3, 0/4).
module tb_avalon_slave_ram;

    typedef struct {
        int         inst;
        logic [3:0] data;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst   [3];
    logic       rd    [3];
    logic       wr    [3];
    logic [3:0] addr  [3];
    logic [3:0] wdat  [3];
    logic       wreq  [3];
    logic       rdv   [3];
    logic [3:0] rdata [3];

    logic [3:0] mem_m [3][16];
    exp_t       sbq[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    logic       mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_slave_ram #(.ADDR_W(4), .DATA_W(4), .WAIT_CYCLES(3), .READ_LATENCY(1)) u_a (
        .clock(clk), .reset(rst[0]), .read(rd[0]), .write(wr[0]), .address(addr[0]),
        .writedata(wdat[0]), .waitrequest(wreq[0]), .readdatavalid(rdv[0]), .readdata(rdata[0]));
    avalon_slave_ram #(.ADDR_W(4), .DATA_W(4), .WAIT_CYCLES(0), .READ_LATENCY(3)) u_b (
        .clock(clk), .reset(rst[1]), .read(rd[1]), .write(wr[1]), .address(addr[1]),
        .writedata(wdat[1]), .waitrequest(wreq[1]), .readdatavalid(rdv[1]), .readdata(rdata[1]));
    avalon_slave_ram #(.ADDR_W(4), .DATA_W(4), .WAIT_CYCLES(0), .READ_LATENCY(4)) u_c (
        .clock(clk), .reset(rst[2]), .read(rd[2]), .write(wr[2]), .address(addr[2]),
        .writedata(wdat[2]), .waitrequest(wreq[2]), .readdatavalid(rdv[2]), .readdata(rdata[2]));

    function automatic int wc(input int i);
        return (i == 0) ? 3 : 0;
    endfunction

    function automatic int lat(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response checker: every cycle, readdatavalid must match whether a response is due now.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                int   idx;
                logic exp_v;
                idx = -1;
                for (int j = 0; j < sbq.size(); j++) begin
                    if (sbq[j].inst == i) begin
                        idx = j;
                        break;
                    end
                end
                exp_v = (idx >= 0) && (sbq[idx].due == cyc);
                chk("rdv", rdv[i], exp_v);
                if (exp_v) begin
                    chk("rdata", rdata[i], sbq[idx].data);
                    sbq.delete(idx);
                end else if (idx >= 0 && sbq[idx].due < cyc) begin
                    sbq.delete(idx);
                end
            end
        end
    end

    // Starts at a negedge; returns at the negedge after the accept edge with the request still driven.
    task automatic do_req(input int i, input logic r, input logic w,
                          input logic [3:0] a, input logic [3:0] d);
        exp_t e;
        rd[i] = r; wr[i] = w; addr[i] = a; wdat[i] = d;
        for (int n = 0; n < wc(i); n++) begin
            #1;
            chk("wait_hold", wreq[i], 1);
            @(negedge clk);
        end
        #1;
        chk("wait_rel", wreq[i], 0);
        if (w) begin
            mem_m[i][a] = d;
        end else if (r) begin
            e.inst = i;
            e.data = mem_m[i][a];
            e.due  = cyc + lat(i);
            sbq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int i, input int n);
        rd[i] = 1'b0; wr[i] = 1'b0;
        #1;
        chk("idle_wait", wreq[i], 1);
        repeat (n) @(negedge clk);
    endtask

    // Reset with a write pending on the same edge; that write must be ignored.
    task automatic do_reset(input int i);
        for (int j = sbq.size() - 1; j >= 0; j--) begin
            if (sbq[j].inst == i) sbq.delete(j);
        end
        rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b1; addr[i] = 4'd0; wdat[i] = 4'd15;
        @(negedge clk);
        rst[i] = 1'b0; wr[i] = 1'b0;
`ifdef AVALON_RAM_CLEAR_EN
        for (int k = 0; k < 16; k++) mem_m[i][k] = 4'd0;
`endif
        #1;
        chk("rst_rdata", rdata[i], 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 4'd0; wdat[i] = 4'd0;
`ifdef AVALON_RAM_CLEAR_EN
            for (int k = 0; k < 16; k++) mem_m[i][k] = 4'd0;
`endif
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset_wreq", wreq[i], 1);
            chk("reset_rdv", rdv[i], 0);
            chk("reset_rdata", rdata[i], 0);
        end
        @(negedge clk);
        mon_en = 1'b1;

        // Instance A: 3 wait states, latency 1
`ifndef AVALON_RAM_CLEAR_EN
        do_req(0, 1'b0, 1'b1, 4'd2, 4'd0); idle(0, 1);
`endif
        do_req(0, 1'b1, 1'b0, 4'd2, 4'd0); idle(0, 3);
        do_req(0, 1'b0, 1'b1, 4'd1, 4'd9); idle(0, 1);
        do_req(0, 1'b1, 1'b0, 4'd1, 4'd0); idle(0, 3);
        chk("rdata_hold", rdata[0], 9);
        do_req(0, 1'b1, 1'b1, 4'd3, 4'd10); idle(0, 4);
        do_req(0, 1'b1, 1'b0, 4'd3, 4'd0); idle(0, 3);

        // Dropping the request before acceptance restarts the wait count
        rd[0] = 1'b1; addr[0] = 4'd1;
        #1; chk("drop_wait0", wreq[0], 1);
        @(negedge clk);
        #1; chk("drop_wait1", wreq[0], 1);
        @(negedge clk);
        rd[0] = 1'b0;
        #1; chk("drop_idle", wreq[0], 1);
        @(negedge clk);
        do_req(0, 1'b1, 1'b0, 4'd1, 4'd0); idle(0, 3);

        // Instance B: no wait states, latency 3, back-to-back traffic
        for (int k = 0; k < 4; k++) do_req(1, 1'b0, 1'b1, 4'(k), 4'(k + 5));
        for (int k = 0; k < 4; k++) do_req(1, 1'b1, 1'b0, 4'(k), 4'd0);
        idle(1, 6);
        do_req(1, 1'b0, 1'b1, 4'd5, 4'd4);
        do_req(1, 1'b1, 1'b0, 4'd5, 4'd0);
        do_req(1, 1'b0, 1'b1, 4'd5, 4'd11);
        do_req(1, 1'b1, 1'b0, 4'd5, 4'd0);
        idle(1, 6);

        // Instance C: latency 4, reset flushes in-flight reads
        do_req(2, 1'b0, 1'b1, 4'd0, 4'd3);
        do_req(2, 1'b0, 1'b1, 4'd1, 4'd12);
        do_req(2, 1'b1, 1'b0, 4'd0, 4'd0);
        do_req(2, 1'b1, 1'b0, 4'd1, 4'd0);
        do_reset(2);
        idle(2, 6);
        do_req(2, 1'b1, 1'b0, 4'd0, 4'd0);
        do_req(2, 1'b1, 1'b0, 4'd1, 4'd0);
        idle(2, 8);

        chk("drain", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
